// File: rtl/fifo_arbiter.sv
// fifo_arbiter: write-side arbiter and occupancy tracker for a shared FIFO.
// Two producers are granted round-robin, one registered add_fifo pulse per
// accepted word. Consumer pops are forwarded as registered pop_fifo pulses.
// A private occupancy count keeps the FIFO from overflowing or underflowing,
// because the FIFO controller's own full/empty flags lag by one cycle.
//
// Build option: define FIFO_ARB_FIXED_PRI_EN to replace round-robin with fixed
// priority. Producer 0 then wins every contention and no pointer is kept.
module fifo_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req0,
  input  logic                    req1,
  input  logic [DATA_WIDTH-1:0]   data0,
  input  logic [DATA_WIDTH-1:0]   data1,
  input  logic                    pop_req,
  output logic                    gnt0,
  output logic                    gnt1,
  output logic                    add_fifo,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    pop_fifo,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    arb_full,
  output logic                    arb_empty
);

  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] ONE_L   = LVL_W'(1);

  // The state register is the grant itself: IDLE, G0 (gnt0) or G1 (gnt1).
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    pop_q, pop_d;
  logic [LVL_W-1:0]        level_q, level_d;
  logic                    space;
  logic                    elig0, elig1;
  logic                    grant_d;

`ifndef FIFO_ARB_FIXED_PRI_EN
  // rr_q == 0: producer 0 wins the next contention; 1: producer 1 wins.
  logic                    rr_q, rr_d;
`endif

  // Level is checked conservatively: a pop at the same edge never frees a slot.
  assign space = (level_q < DEPTH_L);
  // A producer granted this cycle still shows its stale req; skip it once.
  assign elig0 = req0 & (state_q != G0);
  assign elig1 = req1 & (state_q != G1);

  // Next-state, grant selection, data capture and occupancy update.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves a latch.
    state_d = IDLE;
    data_d  = data_q;
    pop_d   = pop_req & (level_q != '0);
    level_d = level_q;
`ifndef FIFO_ARB_FIXED_PRI_EN
    rr_d    = rr_q;
`endif

    if (space) begin
`ifdef FIFO_ARB_FIXED_PRI_EN
      if (elig0)      state_d = G0;
      else if (elig1) state_d = G1;
`else
      if (elig0 && elig1) state_d = rr_q ? G1 : G0;
      else if (elig0)     state_d = G0;
      else if (elig1)     state_d = G1;
`endif
    end

    case (state_d)
      G0:      data_d = data0;
      G1:      data_d = data1;
      default: data_d = data_q;
    endcase

`ifndef FIFO_ARB_FIXED_PRI_EN
    // The pointer always moves to the producer that did not just win.
    if (state_d == G0)      rr_d = 1'b1;
    else if (state_d == G1) rr_d = 1'b0;
`endif

    grant_d = (state_d != IDLE);
    case ({grant_d, pop_d})
      2'b10:   level_d = level_q + ONE_L;
      2'b01:   level_d = level_q - ONE_L;
      default: level_d = level_q;
    endcase
  end

  // Registered state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      pop_q   <= 1'b0;
      level_q <= '0;
`ifndef FIFO_ARB_FIXED_PRI_EN
      rr_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      pop_q   <= pop_d;
      level_q <= level_d;
`ifndef FIFO_ARB_FIXED_PRI_EN
      rr_q    <= rr_d;
`endif
    end
  end

  assign gnt0      = (state_q == G0);
  assign gnt1      = (state_q == G1);
  assign add_fifo  = (state_q != IDLE);
  assign data_out  = data_q;
  assign pop_fifo  = pop_q;
  assign level     = level_q;
  assign arb_full  = (level_q == DEPTH_L);
  assign arb_empty = (level_q == '0);

endmodule

// File: tb/tb_fifo_arbiter.sv
// tb_fifo_arbiter: table-driven check of fifo_arbiter with a scoreboard queue,
// followed by a reactive two-producer sequence at full throughput.
module tb_fifo_arbiter;

  localparam int DW    = 16;
  localparam int DEPTH = 4;
`ifdef FIFO_ARB_FIXED_PRI_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1, pop_req;
  logic [DW-1:0] data0, data1;
  logic          gnt0, gnt1, add_fifo, pop_fifo, arb_full, arb_empty;
  logic [DW-1:0] data_out;
  logic [2:0]    level;

  int checks = 0;
  int errors = 0;

  fifo_arbiter #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .data0(data0), .data1(data1), .pop_req(pop_req),
    .gnt0(gnt0), .gnt1(gnt1), .add_fifo(add_fifo), .data_out(data_out),
    .pop_fifo(pop_fifo), .level(level), .arb_full(arb_full), .arb_empty(arb_empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    bit          r0;
    bit          r1;
    logic [15:0] d0;
    logic [15:0] d1;
    bit          pop;
    bit          g0;
    bit          g1;
    bit          pf;
    int          lvl;
    logic [15:0] dout;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  logic [15:0] exp_data_q[$];

  function automatic vec_t mk(bit rs, bit r0, bit r1, logic [15:0] d0, logic [15:0] d1,
                              bit pop, bit g0, bit g1, bit pf, int lvl, logic [15:0] dout);
    vec_t v;
    v.rst = rs; v.r0 = r0; v.r1 = r1; v.d0 = d0; v.d1 = d1; v.pop = pop;
    v.g0 = g0; v.g1 = g1; v.pf = pf; v.lvl = lvl; v.dout = dout;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Hard bound on run time in case the bench itself gets stuck.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [15:0] h2h_d;
    bit          h2h_g0, h2h_g1;
    vec_t        e;
    int          first;

    // Head-to-head with pointer at producer 1: round-robin grants 1, fixed grants 0.
    h2h_g0 = FIXED;
    h2h_g1 = !FIXED;
    h2h_d  = FIXED ? 16'hC001 : 16'hD000;

    //             rst r0 r1 d0        d1        pop  g0 g1 pf lvl dout
    // reset then idle
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0,  0, 0, 0, 0, 16'h0000));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0,  0, 0, 0, 0, 16'h0000));
    // single producer burst, grants on alternate cycles
    vecs.push_back(mk(1, 1, 0, 16'h1111, 16'h0000, 0,  1, 0, 0, 1, 16'h1111));
    vecs.push_back(mk(1, 1, 0, 16'h2222, 16'h0000, 0,  0, 0, 0, 1, 16'h1111));
    vecs.push_back(mk(1, 1, 0, 16'h2222, 16'h0000, 0,  1, 0, 0, 2, 16'h2222));
    vecs.push_back(mk(1, 1, 0, 16'h3333, 16'h0000, 0,  0, 0, 0, 2, 16'h2222));
    vecs.push_back(mk(1, 1, 0, 16'h3333, 16'h0000, 0,  1, 0, 0, 3, 16'h3333));
    vecs.push_back(mk(1, 1, 0, 16'h4444, 16'h0000, 0,  0, 0, 0, 3, 16'h3333));
    vecs.push_back(mk(1, 1, 0, 16'h4444, 16'h0000, 0,  1, 0, 0, 4, 16'h4444));
    // fifth word waits for a pop; full blocks the grant even on the pop edge
    vecs.push_back(mk(1, 1, 0, 16'h5555, 16'h0000, 0,  0, 0, 0, 4, 16'h4444));
    vecs.push_back(mk(1, 1, 0, 16'h5555, 16'h0000, 0,  0, 0, 0, 4, 16'h4444));
    vecs.push_back(mk(1, 1, 0, 16'h5555, 16'h0000, 1,  0, 0, 1, 3, 16'h4444));
    vecs.push_back(mk(1, 1, 0, 16'h5555, 16'h0000, 0,  1, 0, 0, 4, 16'h5555));
    // drain, then a pop at level 0 is suppressed
    vecs.push_back(mk(1, 0, 0, 16'h5555, 16'h0000, 1,  0, 0, 1, 3, 16'h5555));
    vecs.push_back(mk(1, 0, 0, 16'h5555, 16'h0000, 1,  0, 0, 1, 2, 16'h5555));
    vecs.push_back(mk(1, 0, 0, 16'h5555, 16'h0000, 1,  0, 0, 1, 1, 16'h5555));
    vecs.push_back(mk(1, 0, 0, 16'h5555, 16'h0000, 1,  0, 0, 1, 0, 16'h5555));
    vecs.push_back(mk(1, 0, 0, 16'h5555, 16'h0000, 1,  0, 0, 0, 0, 16'h5555));
    // contention from reset: order 0,1,0,1
    vecs.push_back(mk(0, 1, 1, 16'hA000, 16'hB000, 0,  0, 0, 0, 0, 16'h0000));
    vecs.push_back(mk(1, 1, 1, 16'hA000, 16'hB000, 0,  1, 0, 0, 1, 16'hA000));
    vecs.push_back(mk(1, 1, 1, 16'hA001, 16'hB000, 0,  0, 1, 0, 2, 16'hB000));
    vecs.push_back(mk(1, 1, 1, 16'hA001, 16'hB001, 0,  1, 0, 0, 3, 16'hA001));
    vecs.push_back(mk(1, 1, 1, 16'hA002, 16'hB001, 0,  0, 1, 0, 4, 16'hB001));
    vecs.push_back(mk(1, 0, 0, 16'hA002, 16'hB002, 1,  0, 0, 1, 3, 16'hB001));
    vecs.push_back(mk(1, 0, 0, 16'hA002, 16'hB002, 1,  0, 0, 1, 2, 16'hB001));
    // producer 0 alone, then head-to-head with the pointer at producer 1
    vecs.push_back(mk(1, 1, 0, 16'hC000, 16'hB002, 0,  1, 0, 0, 3, 16'hC000));
    vecs.push_back(mk(1, 0, 0, 16'hC001, 16'hB002, 0,  0, 0, 0, 3, 16'hC000));
    vecs.push_back(mk(1, 1, 1, 16'hC001, 16'hD000, 0,  h2h_g0, h2h_g1, 0, 4, h2h_d));
    vecs.push_back(mk(1, 0, 0, 16'hC002, 16'hD001, 0,  0, 0, 0, 4, h2h_d));
    // full with pop: pop first, grant on the following edge with level held
    vecs.push_back(mk(1, 0, 1, 16'hC002, 16'hE000, 1,  0, 0, 1, 3, h2h_d));
    vecs.push_back(mk(1, 0, 1, 16'hC002, 16'hE000, 1,  0, 1, 1, 3, 16'hE000));
    // mid-operation reset with gnt1 high at level 3, re-grant afterwards
    vecs.push_back(mk(0, 0, 1, 16'hC002, 16'hE001, 0,  0, 0, 0, 0, 16'h0000));
    vecs.push_back(mk(1, 0, 1, 16'hC002, 16'hE001, 0,  0, 1, 0, 1, 16'hE001));
    vecs.push_back(mk(1, 0, 0, 16'hC002, 16'hE001, 1,  0, 0, 1, 0, 16'hE001));
    // empty pop guard: grant goes through, pop waits one edge
    vecs.push_back(mk(1, 1, 0, 16'hF000, 16'hE001, 1,  1, 0, 0, 1, 16'hF000));
    vecs.push_back(mk(1, 0, 0, 16'hF001, 16'hE001, 1,  0, 0, 1, 0, 16'hF000));
    vecs.push_back(mk(1, 0, 0, 16'hF001, 16'hE001, 0,  0, 0, 0, 0, 16'hF000));

    rst = 1'b0; req0 = 1'b0; req1 = 1'b0; pop_req = 1'b0;
    data0 = '0; data1 = '0;

    foreach (vecs[i]) begin
      rst = vecs[i].rst; req0 = vecs[i].r0; req1 = vecs[i].r1;
      data0 = vecs[i].d0; data1 = vecs[i].d1; pop_req = vecs[i].pop;
      exp_q.push_back(vecs[i]);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        check($sformatf("v%0d scoreboard_empty", i), 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("v%0d gnt0", i), 32'(gnt0), 32'(e.g0));
        check($sformatf("v%0d gnt1", i), 32'(gnt1), 32'(e.g1));
        check($sformatf("v%0d add_fifo", i), 32'(add_fifo), 32'(e.g0 | e.g1));
        check($sformatf("v%0d pop_fifo", i), 32'(pop_fifo), 32'(e.pf));
        check($sformatf("v%0d level", i), 32'(level), 32'(e.lvl));
        check($sformatf("v%0d arb_full", i), 32'(arb_full), 32'(e.lvl == DEPTH));
        check($sformatf("v%0d arb_empty", i), 32'(arb_empty), 32'(e.lvl == 0));
        check($sformatf("v%0d data_out", i), 32'(data_out), 32'(e.dout));
      end
    end

    // Two reactive producers with the consumer popping every cycle: one word
    // per cycle, alternating, level settling at 1. The pointer favours
    // producer 1 here after the last producer-0 grant; fixed priority picks 0.
    first = FIXED ? 0 : 1;
    rst = 1'b1; req0 = 1'b1; req1 = 1'b1; pop_req = 1'b1;
    data0 = 16'hA100; data1 = 16'hB100;
    for (int c = 0; c < 8; c++) begin
      int p;
      p = first ^ (c % 2);
      exp_data_q.push_back((p == 1) ? 16'hB100 + 16'(c / 2) : 16'hA100 + 16'(c / 2));
      @(posedge clk);
      #1;
      check($sformatf("tp%0d add_fifo", c), 32'(add_fifo), 32'd1);
      check($sformatf("tp%0d gnt1", c), 32'(gnt1), 32'(p));
      check($sformatf("tp%0d level", c), 32'(level), 32'd1);
      check($sformatf("tp%0d pop_fifo", c), 32'(pop_fifo), 32'(c != 0));
      if (exp_data_q.size() == 0)
        check($sformatf("tp%0d scoreboard_empty", c), 32'd0, 32'd1);
      else
        check($sformatf("tp%0d data_out", c), 32'(data_out), 32'(exp_data_q.pop_front()));
      // Producer reaction: a granted producer presents its next word.
      if (gnt0) data0 = data0 + 16'd1;
      if (gnt1) data1 = data1 + 16'd1;
    end

    req0 = 1'b0; req1 = 1'b0; pop_req = 1'b0;
    @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
